decoder38_pulse: RTL
====================

DECODER38_PULSE -- requirements
Module: decoder38_pulse

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4, meaning output-low cycles per code, legal 1..255.
REQ-002 SHALL have parameter GAP_LEN, default 2, meaning all-high cycles between pulses, legal 0..255.
REQ-003 SHALL have port iClk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port iEI  input  1  enable, active-low; 1 = block disabled.
REQ-006 SHALL have port iCode  input  3  encoded line index 0..7 (encoder-output format).
REQ-007 SHALL have port iValid  input  1  iCode valid this cycle.
REQ-008 SHALL have port oReady  output  1  block can accept iCode this cycle.
REQ-009 SHALL have port oData  output  8  decoded lines, active-low one-hot, registered.
REQ-010 SHALL have port oEO  output  1  cascade enable out, active-low; 0 = enabled and fully idle.

Function
REQ-011 SHALL accept a code on a rising edge where iValid=1 and oReady=1; no other edge accepts.
REQ-012 SHALL drive oReady = (iEI==0) and (pending register empty), from registered state only.
REQ-013 SHALL implement an FSM with states IDLE, PULSE, GAP, an 8-bit down-counter cnt, an active-code register, and a 1-entry pending register (code + full flag).
REQ-014 IDLE + accept: load active code, cnt=PULSE_LEN-1, go PULSE; pending stays empty.
REQ-015 PULSE: oData = all ones except bit[active code]=0; cnt decrements each edge while cnt!=0.
REQ-016 PULSE with cnt==0 and GAP_LEN>0: go GAP, cnt=GAP_LEN-1; oData=8'hFF.
REQ-017 PULSE with cnt==0 and GAP_LEN==0: behave as GAP end (REQ-019) on the same edge.
REQ-018 GAP: oData=8'hFF; cnt decrements while cnt!=0.
REQ-019 GAP end (cnt==0): if pending full, load pending into active, clear pending, go PULSE; else if accept on this edge, load iCode directly into active, go PULSE; else go IDLE.
REQ-020 Accept while in PULSE or GAP (other than the REQ-019 bypass): store iCode in pending, set full.
REQ-021 Latency: code accepted at edge N SHALL drive its line low from edge N (IDLE case) for exactly PULSE_LEN cycles.
REQ-022 Exactly one oData bit SHALL be low in PULSE; none low in IDLE/GAP/disabled.
REQ-023 oEO SHALL be 0 only when iEI=0, state IDLE, pending empty; else 1.
REQ-024 iEI=1 sampled at any edge SHALL abort: state to IDLE, pending cleared, cnt=0, oData=8'hFF on that edge; oReady=0 and oEO=1 while iEI=1.
REQ-025 iEI=1 SHALL take priority over iValid on the same edge; code discarded.
REQ-026 iCode values are all legal; no X propagation when iValid=0 (active/pending registers load only on accept).

Reset
REQ-027 iRst_n=0 SHALL immediately, without clock, force state IDLE, cnt=0, pending empty, active code 0, oData=8'hFF.
REQ-028 After reset release with iEI=0: oReady=1, oEO=0 before first edge.
REQ-029 Reset asserted mid-PULSE or with pending full SHALL discard both codes; no pulse resumes after release.

Verification
REQ-030 Reset, iEI=0, iCode=3 iValid=1 one cycle -> oData=8'b11110111 for 4 cycles, then 8'hFF; oEO 1 during pulse+gap, back to 0 after 6 cycles.
REQ-031 Back-to-back: accept 5 at edge 0, 2 at edge 1 -> oReady=0 edges 1..6; line 5 low edges 0-4, 8'hFF edges 4-6, line 2 (8'b11111011) low edges 6-10.
REQ-032 iEI=1 held, iValid=1 iCode=7 -> oReady=0, oData=8'hFF, oEO=1 throughout; no pulse after iEI returns 0.
REQ-033 iEI raised at edge 2 of a pulse for code 0 with pending code 6 -> oData=8'hFF from edge 2, pending lost, IDLE when iEI lowered.
REQ-034 GAP_LEN=0, PULSE_LEN=1, iValid held high with codes 1,4 -> 8'b11111101 one cycle then 8'b11101111 one cycle, no gap.
REQ-035 iRst_n pulsed low mid-pulse between edges -> oData=8'hFF immediately, oReady=1 after release.

Source files
------------

// File: rtl/decoder38_pulse.sv
// decoder38_pulse: 3-to-8 line decoder that turns each accepted code into a
// timed active-low pulse on its output line. Consecutive pulses are separated
// by an all-high gap. One further code can wait in a single-entry pending
// slot while a pulse or gap is in progress. iEI disables and aborts the block.
// oEO reports "enabled and fully idle" so that several blocks can be cascaded.
module decoder38_pulse #(
    parameter int unsigned PULSE_LEN = 4,  // output-low cycles per code, 1..255
    parameter int unsigned GAP_LEN   = 2   // all-high cycles between pulses, 0..255
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iEI,
    input  logic [2:0] iCode,
    input  logic       iValid,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oEO
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } stateT;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    // With GAP_LEN == 0 the GAP state is never entered, so this wrapped value is unused.
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);
    localparam logic [7:0] ALL_HIGH   = 8'hFF;

    stateT      state;
    logic [7:0] cnt;
    logic [2:0] activeCode;
    logic [2:0] pendCode;
    logic       pendFull;

    logic       accept;
    logic       gapEnd;
    logic       doStart;
    logic       doPend;
    logic [2:0] startCode;

    // Turn a line index into its active-low one-hot output pattern.
    function automatic logic [7:0] lineLow(input logic [2:0] code);
        lineLow = ~(8'b0000_0001 << code);
    endfunction

    // Handshake and cascade outputs depend only on registered state and the enable input.
    assign oReady = !iEI && !pendFull;
    assign oEO    = !(!iEI && (state == IDLE) && !pendFull);
    assign accept = iValid && oReady;

    // End of the inter-pulse gap; with no gap configured, the last pulse cycle acts as the gap end.
    always_comb begin
        gapEnd = 1'b0;
        if (cnt == 8'd0) begin
            if (state == GAP)
                gapEnd = 1'b1;
            else if ((state == PULSE) && (GAP_LEN == 0))
                gapEnd = 1'b1;
        end
    end

    // Decide whether a new pulse starts on this edge, and from which source.
    always_comb begin
        // NOTE: every signal gets a default first so that no path leaves it unassigned (no latch).
        doStart   = 1'b0;
        startCode = iCode;
        if (state == IDLE) begin
            doStart = accept;
        end else if (gapEnd) begin
            if (pendFull) begin
                // A waiting code always wins; oReady is low then, so no accept can collide.
                doStart   = 1'b1;
                startCode = pendCode;
            end else begin
                doStart = accept;
            end
        end
        // Any accept not consumed directly by a start goes into the pending slot.
        doPend = accept && !doStart;
    end

    // Pulse/gap sequencer with registered line outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            activeCode <= 3'd0;
            pendCode   <= 3'd0;
            pendFull   <= 1'b0;
            oData      <= ALL_HIGH;
        end else if (iEI) begin
            // Disable aborts everything; any code offered on this edge is dropped.
            state    <= IDLE;
            cnt      <= 8'd0;
            pendFull <= 1'b0;
            oData    <= ALL_HIGH;
        end else begin
            if (doStart) begin
                state      <= PULSE;
                cnt        <= PULSE_LOAD;
                activeCode <= startCode;
                oData      <= lineLow(startCode);
            end else if (gapEnd) begin
                state <= IDLE;
                oData <= ALL_HIGH;
            end else if ((state == PULSE) && (cnt == 8'd0)) begin
                state <= GAP;
                cnt   <= GAP_LOAD;
                oData <= ALL_HIGH;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
                if (state == PULSE)
                    oData <= lineLow(activeCode);
            end

            if (doStart)
                pendFull <= 1'b0;
            else if (doPend)
                pendFull <= 1'b1;

            if (doPend)
                pendCode <= iCode;
        end
    end

endmodule
